// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the register-file slave.
package axil_pkg;

    localparam logic [1:0] AXIL_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_regfile_bank.sv
// Register storage with one byte-enabled write port and one registered read port.
// A read issued in the same cycle as a write to the same index returns the old contents.
module axil_regfile_bank #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0,
    parameter int          IDX_W     = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_wstrb,
    input  logic             i_re,
    input  logic             i_rok,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [NUM_REGS];
    logic [31:0] r_rdata;
    logic [31:0] w_merged;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[8*gi +: 8] = i_wstrb[gi] ? i_wdata[8*gi +: 8]
                                                     : r_mem[i_widx][8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= RESET_VAL;
        end else if (i_we) begin
            r_mem[i_widx] <= w_merged;
        end
    end

    // Out-of-range reads load zero so the top can drive RDATA straight from here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  r_rdata <= 32'h0;
        else if (i_re) r_rdata <= i_rok ? r_mem[i_ridx] : 32'h0;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axilite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; independent write and read FSMs.
// Define AXIL_REGFILE_WSTRB_EN to add the WSTRB port and byte-lane write enables.
module axilite_slave_regfile
    import axil_pkg::*;
#(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
`ifdef AXIL_REGFILE_WSTRB_EN
    input  logic [3:0]  WSTRB,
`endif
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam int          IDX_W      = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);

    wr_state_t   r_wstate;
    logic        r_aw_held, r_w_held;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    rd_state_t   r_rstate;
    logic        r_rvalid;
    logic [1:0]  r_rresp;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_rd_ok;
    logic [31:0] w_awaddr, w_wdata;
    logic [3:0]  w_wstrb_in, w_wstrb;

`ifdef AXIL_REGFILE_WSTRB_EN
    assign w_wstrb_in = WSTRB;
`else
    assign w_wstrb_in = 4'hF;
`endif

    assign AWREADY  = !r_aw_held && (r_wstate == W_IDLE);
    assign WREADY   = !r_w_held  && (r_wstate == W_IDLE);
    assign w_aw_hs  = AWVALID && AWREADY;
    assign w_w_hs   = WVALID  && WREADY;

    // A channel is "available" if it was held earlier or is handshaking right now.
    assign w_awaddr = r_aw_held ? r_awaddr : AWADDR;
    assign w_wdata  = r_w_held  ? r_wdata  : WDATA;
    assign w_wstrb  = r_w_held  ? r_wstrb  : w_wstrb_in;
    assign w_commit = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_ok  = w_awaddr < ADDR_LIMIT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXIL_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= AWADDR;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= WDATA;
                        r_wstrb  <= w_wstrb_in;
                    end
                    if (w_commit) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wr_ok ? AXIL_OKAY : AXIL_SLVERR;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign BVALID = r_bvalid;
    assign BRESP  = r_bresp;

    assign ARREADY = (r_rstate == R_IDLE);
    assign w_ar_hs = ARVALID && ARREADY;
    assign w_rd_ok = ARADDR < ADDR_LIMIT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rresp  <= AXIL_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= R_DATA;
                        r_rvalid <= 1'b1;
                        r_rresp  <= w_rd_ok ? AXIL_OKAY : AXIL_SLVERR;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        r_rstate <= R_IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign RVALID = r_rvalid;
    assign RRESP  = r_rresp;

    axil_regfile_bank #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_commit && w_wr_ok),
        .i_widx  (w_awaddr[2 +: IDX_W]),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb),
        .i_re    (w_ar_hs),
        .i_rok   (w_rd_ok),
        .i_ridx  (ARADDR[2 +: IDX_W]),
        .o_rdata (RDATA)
    );

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// Directed bench for axilite_slave_regfile with a transaction-level reference model
// checked every cycle on the falling edge.
module tb_axilite_slave_regfile;

    localparam int NREGS = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [3:0]  WSTRB = 4'hF;
    logic        AWVALID = 0, WVALID = 0, BREADY = 1, ARVALID = 0, RREADY = 1;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axilite_slave_regfile #(.NUM_REGS(NREGS), .RESET_VAL(32'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
`ifdef AXIL_REGFILE_WSTRB_EN
        .WSTRB   (WSTRB),
`endif
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as it must be after each rising edge.
    logic [31:0] m_regs [NREGS];
    logic        m_aw_pend, m_w_pend, m_bvalid, m_rvalid;
    logic [31:0] m_awaddr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        logic exp_awr, exp_wr, exp_arr;
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = 32'h0;
            m_aw_pend = 0; m_w_pend = 0; m_bvalid = 0; m_rvalid = 0;
            m_bresp = 0; m_rresp = 0; m_rdata = 0; m_awaddr = 0; m_wdata = 0; m_wstrb = 0;
            check("rst_bvalid", BVALID, 0);
            check("rst_rvalid", RVALID, 0);
            check("rst_bresp", BRESP, 0);
            check("rst_rresp", RRESP, 0);
            check("rst_rdata", RDATA, 0);
        end else begin
            exp_awr = !m_aw_pend && !m_bvalid;
            exp_wr  = !m_w_pend  && !m_bvalid;
            exp_arr = !m_rvalid;
            check("awready", AWREADY, exp_awr);
            check("wready", WREADY, exp_wr);
            check("arready", ARREADY, exp_arr);
            check("bvalid", BVALID, m_bvalid);
            check("rvalid", RVALID, m_rvalid);
            if (m_bvalid) check("bresp", BRESP, m_bresp);
            if (m_rvalid) begin
                check("rdata", RDATA, m_rdata);
                check("rresp", RRESP, m_rresp);
            end
            // Read side first: an AR at this edge sees pre-write contents.
            if (m_rvalid && RREADY) m_rvalid = 0;
            if (ARVALID && exp_arr) begin
                m_rvalid = 1;
                if (ARADDR < NREGS * 4) begin
                    m_rdata = m_regs[ARADDR[4:2]]; m_rresp = 2'b00;
                end else begin
                    m_rdata = 32'h0; m_rresp = 2'b10;
                end
            end
            if (m_bvalid && BREADY) m_bvalid = 0;
            if (AWVALID && exp_awr) begin m_aw_pend = 1; m_awaddr = AWADDR; end
            if (WVALID && exp_wr) begin
                m_w_pend = 1; m_wdata = WDATA;
`ifdef AXIL_REGFILE_WSTRB_EN
                m_wstrb = WSTRB;
`else
                m_wstrb = 4'hF;
`endif
            end
            if (m_aw_pend && m_w_pend && !m_bvalid) begin
                if (m_awaddr < NREGS * 4) begin
                    m_regs[m_awaddr[4:2]] = merge(m_regs[m_awaddr[4:2]], m_wdata, m_wstrb);
                    m_bresp = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
                m_bvalid = 1; m_aw_pend = 0; m_w_pend = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drive the requested channels and hold each until it is accepted; returns one
    // cycle after the last handshake edge.
    task automatic send(input bit do_aw, input bit do_w, input bit do_ar, input logic [31:0] awa,
                        input logic [31:0] wd, input logic [3:0] st, input logic [31:0] ara);
        bit paw, pw, par;
        paw = do_aw; pw = do_w; par = do_ar;
        AWADDR = awa; WDATA = wd; WSTRB = st; ARADDR = ara;
        AWVALID = paw; WVALID = pw; ARVALID = par;
        for (int i = 0; i < 50 && (paw || pw || par); i++) begin
            @(negedge clk);
            if (paw && AWREADY) paw = 0;
            if (pw && WREADY) pw = 0;
            if (par && ARREADY) par = 0;
            tick();
            AWVALID = paw; WVALID = pw; ARVALID = par;
        end
        check("send_accept_timeout", {29'd0, paw, pw, par}, 0);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit seen = 0;
        resp = 2'bxx;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (BVALID) begin seen = 1; resp = BRESP; end
            tick();
        end
        check("bvalid_timeout", {31'd0, seen}, 1);
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
        bit seen = 0;
        data = 'x; resp = 2'bxx;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (RVALID) begin seen = 1; data = RDATA; resp = RRESP; end
            tick();
        end
        check("rvalid_timeout", {31'd0, seen}, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                      output logic [1:0] resp);
        send(1, 1, 0, a, d, st, 0);
        wait_b(resp);
        $display("write addr=%h data=%h strb=%b -> bresp=%b", a, d, st, resp);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        send(0, 0, 1, 0, 0, 0, a);
        wait_r(d, resp);
        $display("read  addr=%h -> rdata=%h rresp=%b", a, d, resp);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r, r2;
        logic [31:0] exp_mix;

        repeat (3) tick();
        reset_n = 1;
        @(negedge clk);
        check("post_reset_awready", AWREADY, 1);
        check("post_reset_wready", WREADY, 1);
        check("post_reset_arready", ARREADY, 1);
        tick();

        // Same-cycle AW and W: response exactly one cycle later.
        send(1, 1, 0, 32'h4, 32'hDEADBEEF, 4'hF, 0);
        @(negedge clk);
        check("same_cycle_bvalid", BVALID, 1);
        check("same_cycle_bresp", BRESP, 2'b00);
        tick();
        rd(32'h4, d, r);
        check("rd4_data", d, 32'hDEADBEEF);
        check("rd4_resp", r, 2'b00);

        // AW at cycle 0, W at cycle 3, BVALID at cycle 4.
        send(1, 0, 0, 32'h8, 0, 4'hF, 0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("aw_first_awready_low", AWREADY, 0);
            check("aw_first_no_bvalid", BVALID, 0);
            tick();
        end
        WDATA = 32'h12345678; WVALID = 1;
        @(negedge clk);
        check("aw_first_awready_low_c3", AWREADY, 0);
        check("aw_first_wready_c3", WREADY, 1);
        check("aw_first_no_bvalid_c3", BVALID, 0);
        tick();
        WVALID = 0;
        @(negedge clk);
        check("aw_first_bvalid_c4", BVALID, 1);
        tick();
        rd(32'h8, d, r);
        check("rd8_data", d, 32'h12345678);

        // Out-of-range write and read.
        wr(32'h20, 32'hCAFEF00D, 4'hF, r);
        check("oor_bresp", r, 2'b10);
        rd(32'h20, d, r);
        check("oor_rdata", d, 32'h0);
        check("oor_rresp", r, 2'b10);
        rd(32'h0, d, r);
        check("oor_no_alias_reg0", d, 32'h0);

        // Stalled B and R channels hold their payloads.
        BREADY = 0;
        send(1, 1, 0, 32'hC, 32'h0BADF00D, 4'hF, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_bvalid", BVALID, 1);
            check("stall_bresp", BRESP, 2'b00);
            check("stall_awready", AWREADY, 0);
            check("stall_wready", WREADY, 0);
            tick();
        end
        BREADY = 1;
        tick();
        @(negedge clk);
        check("stall_bvalid_cleared", BVALID, 0);
        tick();
        RREADY = 0;
        send(0, 0, 1, 0, 0, 0, 32'hC);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_rvalid", RVALID, 1);
            check("stall_rdata", RDATA, 32'h0BADF00D);
            tick();
        end
        RREADY = 1;
        tick();

        // Read in the commit cycle returns the pre-write value.
        wr(32'h4, 32'h11111111, 4'hF, r);
        send(1, 1, 1, 32'h4, 32'h22222222, 4'hF, 32'h4);
        @(negedge clk);
        check("rw_same_rvalid", RVALID, 1);
        check("rw_same_old_data", RDATA, 32'h11111111);
        check("rw_same_bvalid", BVALID, 1);
        tick();
        rd(32'h4, d, r);
        check("rw_same_new_data", d, 32'h22222222);

        // W first, AW two cycles later, with low address bits set.
        send(0, 1, 0, 0, 32'hA5A5A5A5, 4'hF, 0);
        @(negedge clk);
        check("w_first_wready_low", WREADY, 0);
        check("w_first_no_bvalid", BVALID, 0);
        tick();
        send(1, 0, 0, 32'h17, 0, 4'hF, 0);
        @(negedge clk);
        check("w_first_bvalid", BVALID, 1);
        tick();
        rd(32'h14, d, r);
        check("lowbits_ignored", d, 32'hA5A5A5A5);

        // A second request waits while a response is outstanding.
        BREADY = 0;
        send(1, 1, 0, 32'h18, 32'h66666666, 4'hF, 0);
        AWADDR = 32'h1C; WDATA = 32'h77777777; AWVALID = 1; WVALID = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("backpressure_awready", AWREADY, 0);
            tick();
        end
        BREADY = 1;
        send(1, 1, 0, 32'h1C, 32'h77777777, 4'hF, 0);
        wait_b(r);
        check("backpressure_bresp", r, 2'b00);
        rd(32'h18, d, r);
        check("rd18", d, 32'h66666666);
        rd(32'h1C, d, r);
        check("rd1c", d, 32'h77777777);

        // Byte strobes (full word when the strobe port is absent).
        wr(32'h0, 32'hAABBCCDD, 4'hF, r);
        wr(32'h0, 32'h11223344, 4'b0101, r2);
        rd(32'h0, d, r);
`ifdef AXIL_REGFILE_WSTRB_EN
        exp_mix = 32'hAA22CC44;
`else
        exp_mix = 32'h11223344;
`endif
        check("strobe_merge", d, exp_mix);

        for (int i = 0; i < NREGS; i++) rd(32'(i * 4), d, r);

        // Reset during an outstanding write response.
        BREADY = 0;
        send(1, 1, 0, 32'h0, 32'h55555555, 4'hF, 0);
        @(negedge clk);
        check("pre_reset_bvalid", BVALID, 1);
        #2 reset_n = 0;
        #1;
        check("async_reset_bvalid", BVALID, 0);
        check("async_reset_rdata", RDATA, 0);
        tick();
        tick();
        reset_n = 1;
        BREADY = 1;
        rd(32'h0, d, r);
        check("reset_reg0", d, 32'h0);
        rd(32'h8, d, r);
        check("reset_reg2", d, 32'h0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axilite_slave_regfile.md
AXILITE_SLAVE_REGFILE -- requirements
Module: axilite_slave_regfile

Interface
REQ-001 Parameter NUM_REGS, 8, number of 32-bit registers (power of 2, 2..16).
REQ-002 Parameter RESET_VAL, 32'h0, reset value of every register.
REQ-003 Reset reset_n, asynchronous, active-low; clock clk.
REQ-004 clk  input  1  rising-edge clock; reset_n  input  1  async active-low reset.
REQ-005 AWADDR  input  32  write address; AWVALID  input  1; AWREADY  output  1.
REQ-006 WDATA  input  32  write data; WVALID  input  1; WREADY  output  1.
REQ-007 BRESP  output  2  write response; BVALID  output  1; BREADY  input  1.
REQ-008 ARADDR  input  32  read address; ARVALID  input  1; ARREADY  output  1.
REQ-009 RDATA  output  32; RRESP  output  2; RVALID  output  1; RREADY  input  1.
REQ-010 WSTRB  input  4  byte enables, present only when AXIL_REGFILE_WSTRB_EN is defined.

Function
REQ-011 Decode: index = addr[2 +: log2(NUM_REGS)]; addr[1:0] are ignored; addr >= NUM_REGS*4 is out of range.
REQ-012 Write FSM states are W_IDLE, W_RESP; the AW and W channels are captured independently into aw_held/w_held flags.
REQ-013 AWREADY = !aw_held && state==W_IDLE; WREADY = !w_held && state==W_IDLE.
REQ-014 Commit cycle is the cycle both address and data are available (held or handshaking now); the register updates at that edge, then W_RESP with BVALID=1 from the next cycle.
REQ-015 AW and W handshakes in the same cycle give BVALID exactly 1 cycle later.
REQ-016 AW first and W k cycles later (or the reverse) gives BVALID 1 cycle after the later handshake.
REQ-017 BVALID and BRESP are held stable until BREADY; on the BVALID&&BREADY edge the FSM returns to W_IDLE, clears both held flags, and BVALID=0.
REQ-018 Out-of-range write: no register changes, BRESP=SLVERR(2'b10); in range: BRESP=OKAY(2'b00).
REQ-019 Read FSM states are R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-020 On AR handshake, RDATA/RRESP are registered from current contents, and RVALID=1 the next cycle.
REQ-021 RDATA/RRESP are held stable until RREADY; then R_IDLE.
REQ-022 Out-of-range read: RDATA=0, RRESP=SLVERR.
REQ-023 Read and write channels are fully independent and may be active in the same cycle.
REQ-024 A write commit and an AR handshake to the same index in one cycle return the pre-write value.
REQ-025 Valid inputs arriving while READY=0 are ignored until accepted; no data loss, no timeout.

Reset
REQ-026 Reset forces both FSMs to idle, clears held flags, and sets all registers to RESET_VAL.
REQ-027 Reset forces BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
REQ-028 After reset: AWREADY=WREADY=ARREADY=1.
REQ-029 Reset asserted mid-transaction aborts it with no response.

Configuration
REQ-030 AXIL_REGFILE_WSTRB_EN defined: WSTRB port exists, and byte lane i is written only when WSTRB[i]=1 (strobe captured with W).
REQ-031 AXIL_REGFILE_WSTRB_EN undefined: no WSTRB port, and every write is a full 32-bit word.

Structure
REQ-032 Package axil_pkg holds resp codes (AXIL_OKAY=2'b00, AXIL_SLVERR=2'b10) and typedefs wr_state_t, rd_state_t.
REQ-033 Storage plus byte-enable write lives in sub-module axil_regfile_bank (1 write port, 1 registered-read source); the FSMs live in the top.

Verification
REQ-034 AW=0x4 and W=0xDEADBEEF in the same cycle, BREADY=1 -> BVALID next cycle, BRESP=00; AR=0x4 -> RDATA=0xDEADBEEF, RRESP=00.
REQ-035 AW=0x8 at cycle 0, W=0x12345678 at cycle 3 -> AWREADY=0 cycles 1-3, BVALID at cycle 4; readback 0x12345678.
REQ-036 AW=0x20 (NUM_REGS=8) -> BRESP=10, all regs unchanged; AR=0x20 -> RDATA=0, RRESP=10.
REQ-037 BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0; RREADY=0 -> RDATA stable.
REQ-038 reg1=0x11111111, write 0x22222222 to 0x4 with AR 0x4 in the commit cycle -> RDATA=0x11111111; next read 0x22222222.
REQ-039 With WSTRB_EN: reg0=0xAABBCCDD, write 0x11223344 with WSTRB=4'b0101 -> readback 0xAA22CC44; reset mid-write -> BVALID=0, reg0=RESET_VAL.
